instruction_issue_queue: RTL
============================

// Module: instruction_issue_queue
// PURPOSE
//  Consumer end of the fetch interface. Accepts the dual-instruction fetch pair and its PC.
//  Buffers pairs in a small FIFO and issues them to decode, one or two per cycle.
//  Drives PC_enable back to fetch as a stall when the FIFO is full.
//  Honours IF_flush by discarding all queued and incoming instructions.
// PARAMETERS
//  bitsize  11  PC width; matches fetch PC width
//  DEPTH    4   FIFO depth in instruction pairs; power of two, >=2
// PORTS
//  clk            input   1        single clock, rising edge
//  reset          input   1        asynchronous, active-high; clears all state
//  IF_flush       input   1        synchronous flush of queue and incoming pair
//  fetch_valid    input   1        fetch pair below is meaningful this cycle
//  fetch_output1  input   32       first (even-slot) instruction word of pair
//  fetch_output2  input   32       second (odd-slot) instruction word of pair
//  fetch_pc       input   bitsize  PC of the pair
//  PC_enable      output  1        1 = fetch may advance; 0 = stall (FIFO full)
//  issue_ready    input   1        decode can accept an issue this cycle
//  dual_ok        input   1        decode can accept both slots this cycle
//  issue_valid1   output  1        issue_instr1 is issued this cycle
//  issue_instr1   output  32       slot-1 instruction
//  issue_valid2   output  1        issue_instr2 is issued this cycle
//  issue_instr2   output  32       slot-2 instruction
//  issue_pc       output  bitsize  PC of the pair currently at head
// BEHAVIOUR
//  Reset (async, active-high): FIFO empty, rd/wr ptr=0, count=0, FSM=PAIR.
//   Reset outputs: PC_enable=1, issue_valid1/2=0, issue_instr1/2=0, issue_pc=0.
//  Storage: DEPTH entries of {instr1, instr2, pc}. count is 0..DEPTH; ptrs wrap modulo DEPTH.
//  Push: fetch_valid && PC_enable && !IF_flush. Writes pair at wr_ptr.
//  Stall: PC_enable = (count != DEPTH). Combinational from count; no same-cycle pop bypass.
//  Latency: a pair pushed in cycle N is issuable at the earliest in cycle N+1.
//  Issue outputs are combinational from the head entry and FSM state.
//   They are valid only when count>0, issue_ready=1 and IF_flush=0; otherwise valid1/2=0.
//  A slot whose word is 32'h0 is empty (a flushed bubble) and is never issued.
//  FSM:
//   PAIR: head slots both untouched.
//    s1,s2 non-zero, dual_ok=1: valid1=valid2=1; pop; stay PAIR.
//    s1,s2 non-zero, dual_ok=0: valid1=1 only; no pop; -> HALF.
//    Only one slot non-zero: issue that slot (valid1 or valid2); pop; stay PAIR.
//    Both slots zero: no issue; pop; stay PAIR.
//   HALF: slot1 of head already issued.
//    issue_ready=1: valid2=1 (instr2); pop; -> PAIR.
//    issue_ready=0: hold.
//  issue_ready=0: no issue, no pop, FSM holds.
//  Simultaneous push and pop: count unchanged; both ptrs advance.
//  IF_flush=1 (priority over push/pop/issue):
//   next cycle count=0, ptrs=0, FSM=PAIR; incoming pair dropped; valid1/2=0 this cycle.
//  Reset mid-HALF or mid-flush: returns to the reset state immediately.
//  issue_pc = head pc. Decode derives slot-2 PC from issue_pc.
// TESTING
//  1. Push pairs A1/A2, B1/B2; ready=1, dual_ok=1 -> A issued both slots cycle+1, B the next; count returns to 0.
//  2. Push A1/A2; ready=1, dual_ok=0 -> cycle1: valid1 only (A1); cycle2: valid2 only (A2); pop after cycle2.
//  3. ready=0; push 4 pairs -> PC_enable=0 after 4th push; 5th fetch_valid ignored. ready=1 -> PC_enable=1 after one pop.
//  4. Push {32'h0, X} and {Y, 32'h0}, dual_ok=1 -> X issued as valid2 alone, then Y as valid1 alone; no zero word ever issued.
//  5. 3 pairs queued, FSM=HALF; assert IF_flush with fetch_valid=1 -> no issue that cycle; next cycle count=0, FSM=PAIR, PC_enable=1.
//  6. Assert reset asynchronously mid-stream -> outputs hold reset values immediately; wr/rd ptr wrap verified over 10 pairs first.

Source files
------------

// File: rtl/instruction_issue_queue.sv
// Issue queue between fetch and decode: buffers fetched instruction pairs and
// issues one or two words per cycle, stalling fetch when full.
module instruction_issue_queue #(
  parameter int unsigned bitsize = 11,
  parameter int unsigned DEPTH   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               IF_flush,
  input  logic               fetch_valid,
  input  logic [31:0]        fetch_output1,
  input  logic [31:0]        fetch_output2,
  input  logic [bitsize-1:0] fetch_pc,
  output logic               PC_enable,
  input  logic               issue_ready,
  input  logic               dual_ok,
  output logic               issue_valid1,
  output logic [31:0]        issue_instr1,
  output logic               issue_valid2,
  output logic [31:0]        issue_instr2,
  output logic [bitsize-1:0] issue_pc
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0]        instr1;
    logic [31:0]        instr2;
    logic [bitsize-1:0] pc;
  } entry_t;

  typedef enum logic {PAIR, HALF} state_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  state_t        state;
  state_t        state_n;
  logic          push;
  logic          pop;
  logic          nz1;
  logic          nz2;

  assign head         = mem[rd_ptr];
  assign issue_instr1 = head.instr1;
  assign issue_instr2 = head.instr2;
  assign issue_pc     = head.pc;
  assign PC_enable    = (count != CW'(DEPTH));
  assign push         = fetch_valid && PC_enable && !IF_flush;
  assign nz1          = (head.instr1 != 32'h0);
  assign nz2          = (head.instr2 != 32'h0);

  // Storage is cleared on reset so the head reads as zero before any push.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= '{instr1: fetch_output1, instr2: fetch_output2, pc: fetch_pc};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      state  <= PAIR;
    end else if (IF_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      state  <= PAIR;
    end else begin
      state <= state_n;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Issue selection: zero words are bubbles and are skipped; a pair that
  // cannot go dual-issue sends slot 1 now and slot 2 from HALF.
  always_comb begin
    state_n      = state;
    pop          = 1'b0;
    issue_valid1 = 1'b0;
    issue_valid2 = 1'b0;
    if (!IF_flush && issue_ready && (count != '0)) begin
      case (state)
        PAIR: begin
          if (nz1 && nz2) begin
            issue_valid1 = 1'b1;
            if (dual_ok) begin
              issue_valid2 = 1'b1;
              pop          = 1'b1;
            end else begin
              state_n = HALF;
            end
          end else begin
            issue_valid1 = nz1;
            issue_valid2 = nz2;
            pop          = 1'b1;
          end
        end
        HALF: begin
          issue_valid2 = 1'b1;
          pop          = 1'b1;
          state_n      = PAIR;
        end
        default: state_n = PAIR;
      endcase
    end
  end

endmodule
